// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and opcode helpers shared by alu_seq and its bench
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SLL   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_OR    = 4'b1000;
    localparam logic [3:0] OP_AND   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;
    localparam logic [3:0] OP_RSVD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between issue stage, alu_seq and writeback
interface alu_seq_if #(
    parameter int n = 32
);
    logic         InValid;
    logic         InReady;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic [3:0]   ALUSel;
    logic         OutValid;
    logic         OutReady;
    logic [n-1:0] ALUResult;
    logic         Zero;
    logic         Illegal;

    modport master (
        output InValid, A, B, ALUSel, OutReady,
        input  InReady, OutValid, ALUResult, Zero, Illegal
    );

    modport slave (
        input  InValid, A, B, ALUSel, OutReady,
        output InReady, OutValid, ALUResult, Zero, Illegal
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared n-step shift-add multiplier / restoring divider (op: 0 MUL, 1 MULHU, 2 DIVU, 3 REMU)
module alu_muldiv_iter #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic         done,
    output logic [n-1:0] result
);
    localparam int CW = $clog2(n);

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic [1:0]    r_op;
    logic [n-1:0]  r_hi;
    logic [n-1:0]  r_lo;
    logic [n-1:0]  r_b;

    logic [n:0]    w_sum;
    logic [n:0]    w_rs;
    logic [n-1:0]  w_sub;
    logic          w_ge;
    logic [n-1:0]  w_hi_next;
    logic [n-1:0]  w_lo_next;

    // {r_hi,r_lo} is product (mul) or {remainder,quotient} (div); r_b is multiplicand or divisor
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_rs  = {r_hi, r_lo[n-1]};
    assign w_ge  = (w_rs >= {1'b0, r_b});
    assign w_sub = w_rs[n-1:0] - r_b;

    always_comb begin
        w_hi_next = '0;
        w_lo_next = '0;
        if (r_op[1]) begin
            w_hi_next = w_ge ? w_sub : w_rs[n-1:0];
            w_lo_next = {r_lo[n-2:0], w_ge};
        end else begin
            w_hi_next = w_sum[n:1];
            w_lo_next = {w_sum[0], r_lo[n-1:1]};
        end
    end

    assign done   = r_busy && (r_cnt == CW'(n - 1));
    assign result = r_op[0] ? w_hi_next : w_lo_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_op   <= op;
            r_hi   <= '0;
            r_lo   <= op[1] ? A : B;
            r_b    <= op[1] ? B : A;
        end else if (r_busy) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked RV32I ALU with registered result; ALU_SEQ_MULDIV_EN adds the iterative mul/div unit
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int n = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(n);

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic [n-1:0]  r_result;
    logic          r_zero;
    logic          r_illegal;
    logic [n-1:0]  w_simple;
    logic          w_simple_ill;
    logic [SW-1:0] w_shamt;
    logic          w_is_md;
    logic          w_md_done;
    logic [n-1:0]  w_md_result;

`ifdef ALU_SEQ_MULDIV_EN
    assign w_is_md = is_muldiv(bus.ALUSel);

    alu_muldiv_iter #(.n(n)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_accept && w_is_md),
        .op     (2'(bus.ALUSel - OP_MUL)),
        .A      (bus.A),
        .B      (bus.B),
        .done   (w_md_done),
        .result (w_md_result)
    );
`else
    assign w_is_md     = 1'b0;
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
`endif

    assign w_shamt = bus.B[SW-1:0];

    always_comb begin
        w_simple     = '0;
        w_simple_ill = 1'b0;
        case (bus.ALUSel)
            OP_ADD:   w_simple = bus.A + bus.B;
            OP_SUB:   w_simple = bus.A - bus.B;
            OP_SLL:   w_simple = bus.A << w_shamt;
            OP_SLT:   w_simple = {{(n-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU:  w_simple = {{(n-1){1'b0}}, (bus.A < bus.B)};
            OP_XOR:   w_simple = bus.A ^ bus.B;
            OP_SRL:   w_simple = bus.A >> w_shamt;
            OP_SRA:   w_simple = $unsigned($signed(bus.A) >>> w_shamt);
            OP_OR:    w_simple = bus.A | bus.B;
            OP_AND:   w_simple = bus.A & bus.B;
            OP_PASSB: w_simple = bus.B;
            OP_RSVD: begin
                w_simple     = bus.A;
                w_simple_ill = 1'b1;
            end
            // mul/div opcodes reach here only when the iterative unit is absent
            default:  w_simple_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.InValid) begin
                    w_accept = 1'b1;
                    w_next   = w_is_md ? CALC : DONE;
                end
            end
            CALC: begin
                if (w_md_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_is_md) begin
            r_result  <= w_simple;
            r_zero    <= (w_simple == '0);
            r_illegal <= w_simple_ill;
        end else if ((r_state == CALC) && w_md_done) begin
            r_result  <= w_md_result;
            r_zero    <= (w_md_result == '0);
            r_illegal <= 1'b0;
        end
    end

    assign bus.InReady   = (r_state == IDLE);
    assign bus.OutValid  = (r_state == DONE);
    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
    assign bus.Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - vector table plus handshake corner sequences for alu_seq (adapts to ALU_SEQ_MULDIV_EN)
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.n(N)) bus_if ();

    alu_seq #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (bus_if.InReady !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", {31'b0, bus_if.InReady}, 32'd1);
        bus_if.InValid = 1'b1;
        bus_if.ALUSel  = op;
        bus_if.A       = a;
        bus_if.B       = b;
        @(posedge clk);
        #1;
        // scramble operands so a design that re-reads them after accept gets caught
        bus_if.InValid = 1'b0;
        bus_if.A       = $urandom;
        bus_if.B       = $urandom;
        bus_if.ALUSel  = 4'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        logic ready_seen;
        bus_if.OutReady = 1'b1;
        issue(v.op, v.a, v.b);
        lat        = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            ready_seen |= bus_if.InReady;
        end while (bus_if.OutValid !== 1'b1 && lat < 100);
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_result", idx), bus_if.ALUResult, v.res);
        check($sformatf("v%0d_zero", idx), {31'b0, bus_if.Zero}, {31'b0, v.zero});
        check($sformatf("v%0d_illegal", idx), {31'b0, bus_if.Illegal}, {31'b0, v.ill});
        check($sformatf("v%0d_inready_low_busy", idx), {31'b0, ready_seen}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_inready_back", idx), {31'b0, bus_if.InReady}, 32'd1);
        check($sformatf("v%0d_outvalid_drop", idx), {31'b0, bus_if.OutValid}, 32'd0);
        check($sformatf("v%0d_result_hold", idx), bus_if.ALUResult, v.res);
    endtask

    initial begin
        logic seen;

        rst             = 1'b1;
        bus_if.InValid  = 1'b0;
        bus_if.A        = '0;
        bus_if.B        = '0;
        bus_if.ALUSel   = OP_ADD;
        bus_if.OutReady = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_inready", {31'b0, bus_if.InReady}, 32'd1);
        check("rst_outvalid", {31'b0, bus_if.OutValid}, 32'd0);
        check("rst_result", bus_if.ALUResult, 32'd0);
        check("rst_zero", {31'b0, bus_if.Zero}, 32'd1);
        check("rst_illegal", {31'b0, bus_if.Illegal}, 32'd0);

        vecs.push_back('{OP_ADD,   32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1});
        vecs.push_back('{OP_SUB,   32'd3,         32'd3,         32'd0,         1'b1, 1'b0, 1});
        vecs.push_back('{OP_ADD,   32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0, 1});
        vecs.push_back('{OP_SUB,   32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b0, 1});
        vecs.push_back('{OP_SLT,   32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0, 1});
        vecs.push_back('{OP_SLTU,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0, 1});
        vecs.push_back('{OP_SRA,   32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b0, 1});
        vecs.push_back('{OP_SLL,   32'h40000001,  32'h21,        32'h80000002,  1'b0, 1'b0, 1});
        vecs.push_back('{OP_SRL,   32'h80000000,  32'd31,        32'd1,         1'b0, 1'b0, 1});
        vecs.push_back('{OP_XOR,   32'h0000F0F0,  32'h00000FF0,  32'h0000FF00,  1'b0, 1'b0, 1});
        vecs.push_back('{OP_OR,    32'h0000F000,  32'h0000000F,  32'h0000F00F,  1'b0, 1'b0, 1});
        vecs.push_back('{OP_AND,   32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0, 1'b0, 1});
        vecs.push_back('{OP_PASSB, 32'hDEADBEEF,  32'h12345000,  32'h12345000,  1'b0, 1'b0, 1});
`ifdef ALU_SEQ_MULDIV_EN
        vecs.push_back('{OP_MUL,   32'h00010000,  32'h00010000,  32'd0,         1'b1, 1'b0, 33});
        vecs.push_back('{OP_MULHU, 32'h00010000,  32'h00010000,  32'd1,         1'b0, 1'b0, 33});
        vecs.push_back('{OP_MUL,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         1'b0, 1'b0, 33});
        vecs.push_back('{OP_MULHU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, 1'b0, 33});
        vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 33});
        vecs.push_back('{OP_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 33});
        vecs.push_back('{OP_DIVU,  32'd100,       32'd0,         32'hFFFFFFFF,  1'b0, 1'b0, 33});
        vecs.push_back('{OP_REMU,  32'd100,       32'd0,         32'd100,       1'b0, 1'b0, 33});
`else
        vecs.push_back('{OP_MUL,   32'd3,         32'd4,         32'd0,         1'b1, 1'b1, 1});
        vecs.push_back('{OP_MULHU, 32'd3,         32'd4,         32'd0,         1'b1, 1'b1, 1});
        vecs.push_back('{OP_DIVU,  32'd100,       32'd7,         32'd0,         1'b1, 1'b1, 1});
        vecs.push_back('{OP_REMU,  32'd100,       32'd7,         32'd0,         1'b1, 1'b1, 1});
`endif
        vecs.push_back('{OP_RSVD,  32'h00000055,  32'd7,         32'h00000055,  1'b0, 1'b1, 1});

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

`ifdef ALU_SEQ_MULDIV_EN
        bus_if.OutReady = 1'b1;
        issue(OP_MUL, 32'd7, 32'd9);
        repeat (10) @(negedge clk);
        check("calc_abort_busy", {31'b0, bus_if.InReady}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("calc_abort_inready", {31'b0, bus_if.InReady}, 32'd1);
        check("calc_abort_outvalid", {31'b0, bus_if.OutValid}, 32'd0);
        check("calc_abort_result", bus_if.ALUResult, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus_if.OutValid;
        end
        check("calc_abort_no_result", {31'b0, seen}, 32'd0);
        run_vec('{OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, 33}, 100);
`endif

        bus_if.OutReady = 1'b0;
        issue(OP_ADD, 32'h10, 32'h20);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus_if.InValid = 1'b1;
                bus_if.ALUSel  = OP_SUB;
                bus_if.A       = 32'd9;
                bus_if.B       = 32'd9;
            end
            if (i == 2) begin
                bus_if.InValid = 1'b0;
            end
            check($sformatf("bp%0d_outvalid", i), {31'b0, bus_if.OutValid}, 32'd1);
            check($sformatf("bp%0d_inready", i), {31'b0, bus_if.InReady}, 32'd0);
            check($sformatf("bp%0d_result", i), bus_if.ALUResult, 32'h30);
            @(negedge clk);
        end
        bus_if.OutReady = 1'b1;
        @(negedge clk);
        check("bp_release_inready", {31'b0, bus_if.InReady}, 32'd1);
        check("bp_release_outvalid", {31'b0, bus_if.OutValid}, 32'd0);
        check("bp_release_result", bus_if.ALUResult, 32'h30);
        @(negedge clk);
        check("bp_pulse_ignored", {31'b0, bus_if.OutValid}, 32'd0);
        check("bp_pulse_zero", {31'b0, bus_if.Zero}, 32'd0);

        bus_if.OutReady = 1'b0;
        issue(OP_ADD, 32'd1, 32'd2);
        @(negedge clk);
        check("done_abort_pre_valid", {31'b0, bus_if.OutValid}, 32'd1);
        check("done_abort_pre_result", bus_if.ALUResult, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("done_abort_outvalid", {31'b0, bus_if.OutValid}, 32'd0);
        check("done_abort_inready", {31'b0, bus_if.InReady}, 32'd1);
        check("done_abort_result", bus_if.ALUResult, 32'd0);
        check("done_abort_zero", {31'b0, bus_if.Zero}, 32'd1);
        @(negedge clk);
        check("done_abort_stays_idle", {31'b0, bus_if.OutValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parametrised ALU for the RISC-V datapath and the successor to the single-cycle combinational ALU. It adds a valid/ready handshake on both sides, registered results, full RV32I arithmetic, logic, shift and compare ops, and an iterative unsigned multiply/divide unit. It sits between the register-file read stage and writeback. The control FSM stalls the pipeline on `InReady`/`OutValid`.

## Interface
- `n`, 32, datapath width. Must be a power of two, ≥ 8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `InValid`  in  1  operand/opcode valid.
- `InReady`  out  1  block can accept an operation.
- `A`, `B`  in  n  operands.
- `ALUSel`  in  4  opcode (encoding below).
- `OutValid`  out  1  result valid.
- `OutReady`  in  1  consumer takes the result.
- `ALUResult`  out  n  result.
- `Zero`  out  1  `ALUResult == 0`, registered with the result.
- `Illegal`  out  1  opcode unsupported in this build, valid with `OutValid`.

## Operation
- **Opcodes:**
  - 0000 ADD
  - 0001 SUB
  - 0010 SLL
  - 0011 SLT (signed)
  - 0100 SLTU
  - 0101 XOR
  - 0110 SRL
  - 0111 SRA
  - 1000 OR
  - 1001 AND
  - 1010 MUL (low n bits)
  - 1011 MULHU (high n bits, unsigned)
  - 1100 DIVU
  - 1101 REMU
  - 1110 PASSB (B, used for LUI)
  - 1111 reserved: result = A, `Illegal` = 1.
- **Arithmetic and shift rules:**
  - Arithmetic wraps modulo 2^n.
  - Shift amount is `B[$clog2(n)-1:0]`.
  - SLT and SLTU produce {0…0, bit}.
- **Divide by zero:** DIVU returns all-ones and REMU returns A. `Illegal` stays 0.
- **Operand capture:** an operation is accepted on a cycle where `InValid && InReady`. A, B and ALUSel are captured on that edge, and later input changes are ignored.
- **FSM states:** IDLE, CALC, DONE.
  - IDLE: `InReady` = 1. On accept, a simple op (all except 1010–1101) computes into `ALUResult` and goes to DONE. A mul/div op loads the iterative unit and goes to CALC.
  - CALC: a counter runs 0..n-1 with one shift-add (MUL/MULHU) or one restoring-subtract (DIVU/REMU) step per cycle. On count n-1 the result is written and the FSM goes to DONE.
  - DONE: `OutValid` = 1. The FSM goes to IDLE on `OutReady`.
- **Result hold:** `ALUResult`, `Zero` and `Illegal` hold stable from `OutValid` rise until handshake completion, and also afterwards until the next result is written.
- **Accept only from IDLE:** `InValid` asserted during CALC or DONE is not accepted. Throughput is one simple op per 2 cycles.
- **Reset:**
  - Reset values: state = IDLE, `InReady` = 1, `OutValid` = 0, `ALUResult` = 0, `Zero` = 1, `Illegal` = 0, counter = 0.
  - Reset in CALC or DONE aborts the operation. No result is ever presented for it.
- **Overlapping events:** `rst` has priority over everything. In DONE, an asserted `OutReady` means IDLE next cycle regardless of `InValid`.

## Timing
- Simple ops: `OutValid` is high in cycle T+1 after an accept at edge T.
- Mul/div ops: `OutValid` is high in cycle T+n+1 (n CALC cycles). For n = 32 that is 33 cycles.
- `InReady` is a pure function of state (IDLE). `OutValid` is a pure function of state (DONE). There is no combinational path from inputs to outputs.
- With `OutReady` held high, `InReady` returns 1 one cycle after the first `OutValid` cycle.

## Configuration
- Macro: `ALU_SEQ_MULDIV_EN`.
- Defined: opcodes 1010–1101 run on the iterative unit as above.
- Undefined:
  - The iterative unit and counter are not instantiated.
  - Opcodes 1010–1101 behave as simple ops: `ALUResult` = 0, `Illegal` = 1, latency 1.
  - The CALC state is unreachable.

## Structure
- Package `alu_seq_pkg` holds:
  - the `ALUSel` opcode localparams;
  - the FSM state enum (IDLE/CALC/DONE);
  - the `is_muldiv(op)` function.
- Sub-module `alu_muldiv_iter` holds the shared shift-add multiplier and restoring divider.
  - Ports: `clk`, `rst`, `start`, op[1:0], A, B, `done`, `result`.
  - It is instantiated only under `ALU_SEQ_MULDIV_EN`.
- The simple-op datapath and the FSM live in `alu_seq`.

## Test plan
All scenarios use n = 32.
- **Simple ops:** ADD 5+7 → 12, `Zero` = 0, `OutValid` exactly 1 cycle after accept. SUB 3−3 → 0, `Zero` = 1.
- **Compare and shift:** SLT 0xFFFFFFFF, 1 → 1. SLTU with the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000. SLL by B = 0x21 → shift by 1.
- **Multiply:** MUL 0x00010000 × 0x00010000 → 0. MULHU with the same operands → 1. `OutValid` exactly 33 cycles after accept, and `InReady` = 0 throughout.
- **Divide:** DIVU 100/7 → 14 and REMU → 2. DIVU 100/0 → 0xFFFFFFFF and REMU 100/0 → 100, both with `Illegal` = 0.
- **Backpressure and abort:** hold `OutReady` low for 5 cycles. `ALUResult` stays stable, `InReady` = 0, and an `InValid` pulse is ignored. Separately, assert `rst` in CALC cycle 10: next cycle IDLE, `OutValid` = 0, `ALUResult` = 0.
- **Macro undefined:** MUL 3×4 → `ALUResult` = 0, `Illegal` = 1, latency 1. Opcode 1111 with A = 0x55 → 0x55, `Illegal` = 1, in both builds.
